// File: rtl/spi_peek_bank.sv
// spi_peek_bank: SPI slave giving a microcontroller peek/poke access to a bank of CHANNELS registers
// Ports: clk, reset (async, active high); ucSCLK/ucMOSI/ucSEL_ in, ucMISO out (SPI slave pins);
//   data_in/data_out packed per channel at [k*DATA_BITS +: DATA_BITS]; wr_stb/rd_stb per-channel
//   one-clk strobes; frame_err one-clk pulse on a short/aborted frame; busy while a frame is open.
module spi_peek_bank #(
  parameter int DATA_BITS = 32,
  parameter int CHANNELS = 4,
  parameter int CPOL = 0,
  parameter int CPHA = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ucSCLK,
  input  logic                          ucMOSI,
  output logic                          ucMISO,
  input  logic                          ucSEL_,
  input  logic [CHANNELS*DATA_BITS-1:0] data_in,
  output logic [CHANNELS*DATA_BITS-1:0] data_out,
  output logic [CHANNELS-1:0]           wr_stb,
  output logic [CHANNELS-1:0]           rd_stb,
  output logic                          frame_err,
  output logic                          busy
);
  localparam logic [1:0] IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, DONE = 2'd3;
  localparam int CW = $clog2(DATA_BITS);
  localparam logic POL = CPOL != 0;
  localparam logic SAMPLE_RISE = (CPOL != 0) == (CPHA != 0);
  logic [2:0] sclk_s, sel_s;
  logic [1:0] mosi_s;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [7:0] cmd, cmd_next;
  logic [DATA_BITS-1:0] in_sr, out_sr, cap;
  logic hold;
  logic [CHANNELS-1:0] rd_vec, wr_vec;
  logic rise, fall, sample, shift, sel_rise, sel_fall;
  // edges are taken between the two oldest synchroniser stages
  assign rise = sclk_s[1] & ~sclk_s[2];
  assign fall = ~sclk_s[1] & sclk_s[2];
  assign sample = SAMPLE_RISE ? rise : fall;
  assign shift = SAMPLE_RISE ? fall : rise;
  assign sel_rise = sel_s[1] & ~sel_s[2];
  assign sel_fall = ~sel_s[1] & sel_s[2];
  assign cmd_next = {cmd[6:0], mosi_s[1]};
  assign busy = state != IDLE;
  assign ucMISO = state == DATA && out_sr[DATA_BITS-1];
  // channel decode: out-of-range indices match nothing, giving a zero load and no strobes
  always_comb begin
    cap = '0;
    rd_vec = '0;
    wr_vec = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cmd_next[6:0] == 7'(k)) begin
        cap = data_in[k*DATA_BITS +: DATA_BITS];
        rd_vec[k] = 1'b1;
      end
      if (state == DONE && cmd[7] && cmd[6:0] == 7'(k)) wr_vec[k] = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sclk_s <= {3{POL}};
      sel_s <= 3'b111;
      mosi_s <= 2'b00;
      state <= IDLE;
      cnt <= '0;
      cmd <= '0;
      in_sr <= '0;
      out_sr <= '0;
      hold <= 1'b0;
      data_out <= '0;
      wr_stb <= '0;
      rd_stb <= '0;
      frame_err <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], ucSCLK};
      sel_s <= {sel_s[1:0], ucSEL_};
      mosi_s <= {mosi_s[0], ucMOSI};
      wr_stb <= '0;
      rd_stb <= '0;
      frame_err <= 1'b0;
      if (sel_rise) begin
        state <= IDLE;
        frame_err <= state == CMD || state == DATA;
        wr_stb <= wr_vec;
        for (int k = 0; k < CHANNELS; k++)
          if (wr_vec[k]) data_out[k*DATA_BITS +: DATA_BITS] <= in_sr;
      end else if (state == IDLE) begin
        if (sel_fall) begin
          state <= CMD;
          cnt <= '0;
        end
      end else if (state == CMD) begin
        if (sample) begin
          cmd <= cmd_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(7)) begin
            state <= DATA;
            cnt <= '0;
            out_sr <= cap;
            rd_stb <= rd_vec;
            hold <= 1'b1;
          end
        end
      end else if (state == DATA) begin
        if (sample) begin
          in_sr <= {in_sr[DATA_BITS-2:0], mosi_s[1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DATA_BITS - 1)) state <= DONE;
        end
        // with CPHA=1 the MSB must survive the leading edge that directly follows the load
        if (shift) begin
          if (CPHA != 0 && hold) hold <= 1'b0;
          else out_sr <= {out_sr[DATA_BITS-2:0], 1'b0};
        end
      end
    end
endmodule

// File: tb/tb_spi_peek_bank.sv
// tb_spi_peek_bank: randomized directed bench for spi_peek_bank in all four SPI modes at once
module tb_spi_peek_bank;
  localparam int DB = 32;
  localparam int NC = 4;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] sclk, mosi, sel_n, miso, err, busy;
  logic [NC*DB-1:0] din;
  logic [NC*DB-1:0] dout [4];
  logic [NC-1:0] wr [4];
  logic [NC-1:0] rd [4];
  int n_chk = 0;
  int n_fail = 0;
  int wr_n [4] = '{default: 0};
  int rd_n [4] = '{default: 0};
  int err_n [4] = '{default: 0};
  logic [NC-1:0] wr_last [4];
  logic [NC-1:0] rd_last [4];
  logic [DB-1:0] exp_do [4][NC];
  always #5 clk = ~clk;
  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_peek_bank #(.DATA_BITS(DB), .CHANNELS(NC), .CPOL(m / 2), .CPHA(m % 2)) u (
      .clk(clk), .reset(reset), .ucSCLK(sclk[m]), .ucMOSI(mosi[m]), .ucMISO(miso[m]),
      .ucSEL_(sel_n[m]), .data_in(din), .data_out(dout[m]), .wr_stb(wr[m]), .rd_stb(rd[m]),
      .frame_err(err[m]), .busy(busy[m]));
  end
  always @(negedge clk)
    for (int i = 0; i < 4; i++) begin
      if (wr[i] != '0) begin wr_n[i]++; wr_last[i] = wr[i]; end
      if (rd[i] != '0) begin rd_n[i]++; rd_last[i] = rd[i]; end
      if (err[i]) err_n[i]++;
    end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [NC*DB-1:0] pack(input int m);
    logic [NC*DB-1:0] r;
    for (int k = 0; k < NC; k++) r[k*DB +: DB] = exp_do[m][k];
    return r;
  endfunction
  // Master side. The slave's MISO lags its pins by ~2.5 clk of synchroniser delay, so CPHA=0
  // runs SCLK at the 4x limit and CPHA=1 runs it slowly; MISO is read just before each sample edge.
  task automatic frame(input int m, input logic [7:0] cmd, input logic [31:0] pay, input int nbits,
                       input bit desel, input bit scram, output logic [39:0] got);
    int h;
    logic [39:0] f;
    h = (m % 2 == 1) ? 8 : 2;
    f = {cmd, pay};
    got = '0;
    sel_n[m] = 1'b0;
    clks(4);
    for (int i = 0; i < nbits; i++) begin
      if (scram && i == 24) for (int k = 0; k < NC; k++) din[k*DB +: DB] = $urandom;
      if (m % 2 == 0) begin
        mosi[m] = f[39-i];
        clks(h);
        got[39-i] = miso[m];
        sclk[m] = ~sclk[m];
        clks(h);
        sclk[m] = ~sclk[m];
      end else begin
        sclk[m] = ~sclk[m];
        mosi[m] = f[39-i];
        clks(h);
        got[39-i] = miso[m];
        sclk[m] = ~sclk[m];
        clks(h);
      end
    end
    clks(4);
    if (desel) begin
      sel_n[m] = 1'b1;
      clks(4);
    end
  endtask
  task automatic run(input int m, input logic [7:0] cmd, input logic [31:0] pay, input int nbits,
                     input bit scram, input string tag);
    int ch, w0, r0, e0;
    bit valid, full, wrote, read;
    logic [31:0] cap;
    logic [39:0] got;
    string t;
    ch = int'(cmd[6:0]);
    valid = ch < NC;
    full = nbits == 40;
    wrote = full && cmd[7] && valid;
    read = nbits >= 8 && valid;
    cap = '0;
    if (valid) cap = din[ch*DB +: DB];
    w0 = wr_n[m];
    r0 = rd_n[m];
    e0 = err_n[m];
    frame(m, cmd, pay, nbits, 1'b1, scram, got);
    if (wrote) exp_do[m][ch] = pay;
    t = $sformatf("mode%0d %s cmd=%h", m, tag, cmd);
    chk({t, " data_out"}, dout[m], pack(m));
    chk({t, " wr_stb count"}, wr_n[m] - w0, wrote ? 1 : 0);
    if (wrote) chk({t, " wr_stb mask"}, wr_last[m], 1 << ch);
    chk({t, " rd_stb count"}, rd_n[m] - r0, read ? 1 : 0);
    if (read) chk({t, " rd_stb mask"}, rd_last[m], 1 << ch);
    chk({t, " frame_err count"}, err_n[m] - e0, full ? 0 : 1);
    chk({t, " busy"}, busy[m], 1'b0);
    if (full) chk({t, " miso stream"}, got, {8'h00, cap});
    clks(2);
  endtask
  initial begin
    logic [39:0] junk;
    int w0, e0;
    reset = 1'b1;
    sel_n = 4'b1111;
    sclk = 4'b1100;
    mosi = 4'b0000;
    din = '0;
    for (int m = 0; m < 4; m++) for (int k = 0; k < NC; k++) exp_do[m][k] = '0;
    clks(3);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("mode%0d reset data_out", m), dout[m], '0);
      chk($sformatf("mode%0d reset strobes", m), {wr[m], rd[m], err[m], busy[m], miso[m]}, '0);
    end
    reset = 1'b0;
    clks(3);
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < NC; k++) din[k*DB +: DB] = $urandom;
      run(m, 8'h82, 32'hDEADBEEF, 40, 1'b0, "write ch2");
      din[1*DB +: DB] = 32'h12345678;
      run(m, 8'h01, $urandom, 40, 1'b1, "read ch1");
      run(m, 8'h80, $urandom, 20, 1'b0, "abort after 20 bits");
      run(m, 8'h80, $urandom, 40, 1'b0, "write ch0 after abort");
      run(m, 8'h85, 32'hFFFFFFFF, 40, 1'b0, "write bad ch5");
      run(m, 8'h83, $urandom, 5, 1'b0, "short cmd");
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < NC; k++) din[k*DB +: DB] = $urandom;
        run(m, {1'($urandom_range(0, 1)), 7'($urandom_range(0, 5))}, $urandom, 40, 1'b0, "random");
      end
    end
    w0 = wr_n[3];
    e0 = err_n[3];
    frame(3, 8'h83, $urandom, 18, 1'b0, 1'b0, junk);
    reset = 1'b1;
    clks(2);
    for (int m = 0; m < 4; m++) chk($sformatf("mode%0d mid-frame reset data_out", m), dout[m], '0);
    chk("mode3 mid-frame reset miso/busy", {miso[3], busy[3]}, 2'b00);
    sel_n[3] = 1'b1;
    clks(2);
    reset = 1'b0;
    for (int m = 0; m < 4; m++) for (int k = 0; k < NC; k++) exp_do[m][k] = '0;
    clks(4);
    chk("mode3 mid-frame reset wr_stb count", wr_n[3] - w0, 0);
    chk("mode3 mid-frame reset frame_err count", err_n[3] - e0, 0);
    run(3, 8'h83, $urandom, 40, 1'b0, "write ch3 after reset");
    run(3, 8'h03, $urandom, 40, 1'b0, "read ch3 after reset");
    run(0, 8'h81, $urandom, 40, 1'b0, "write ch1 after reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_peek_bank.md
SPI_PEEK_BANK -- requirements
Module: spi_peek_bank

Interface
REQ-001 Parameter DATA_BITS, default 32, payload width per channel; legal range 8..64.
REQ-002 Parameter CHANNELS, default 4, number of peek/poke channels; legal range 1..128.
REQ-003 Parameter CPOL, default 0, SCLK idle level.
REQ-004 Parameter CPHA, default 0, SCLK phase.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 ucSCLK  in  1  SPI clock from microcontroller, asynchronous to clk.
REQ-008 ucMOSI  in  1  SPI data from master.
REQ-009 ucMISO  out  1  SPI data to master.
REQ-010 ucSEL_  in  1  SPI select, active low.
REQ-011 data_in  in  CHANNELS*DATA_BITS  read sources; channel k at bits [k*DATA_BITS +: DATA_BITS].
REQ-012 data_out  out  CHANNELS*DATA_BITS  written registers, same packing.
REQ-013 wr_stb  out  CHANNELS  one-clk pulse when channel k's data_out updates.
REQ-014 rd_stb  out  CHANNELS  one-clk pulse when channel k's data_in is captured for readout.
REQ-015 frame_err  out  1  one-clk pulse on an aborted or short frame.
REQ-016 busy  out  1  high while a frame is in progress (state not IDLE).

Function
REQ-017 ucSCLK, ucSEL_ and ucMOSI SHALL pass through 3-, 3- and 2-stage clk synchronisers; edge detects use the two oldest stages.
REQ-018 Sample edge SHALL be SCLK rising when CPOL==CPHA, else falling; shift edge is the opposite edge.
REQ-019 Frame: 8-bit command MSB first (bit7 = write flag W, bits6..0 = channel index CH), then DATA_BITS payload bits MSB first.
REQ-020 States: IDLE, CMD, DATA, DONE; synchronised select fall moves IDLE->CMD and clears the bit counter.
REQ-021 CMD->DATA at the 8th sample edge; in that clk cycle, if CH<CHANNELS, the out-shift register loads data_in of channel CH and rd_stb[CH] pulses; if CH>=CHANNELS, loads zero and no rd_stb.
REQ-022 rd_stb SHALL pulse for both read (W=0) and write (W=1) frames to a valid CH.
REQ-023 DATA->DONE at the DATA_BITS-th payload sample edge; further SCLK edges in DONE are ignored and ucMISO is 0.
REQ-024 ucMISO SHALL be the out-shift MSB in DATA state and 0 otherwise.
REQ-025 CPHA=0: the out-shift register shifts left on every shift edge in DATA.
REQ-026 CPHA=1: the first shift edge after the load SHALL NOT shift; each later shift edge in DATA shifts left.
REQ-027 Select rise in DONE with W=1 and CH<CHANNELS SHALL write the payload to data_out channel CH and pulse wr_stb[CH] in the same clk cycle; other channels are unchanged.
REQ-028 Select rise in DONE with W=0 or CH>=CHANNELS SHALL leave data_out unchanged with no wr_stb.
REQ-029 Select rise in CMD or DATA SHALL pulse frame_err, leave data_out unchanged and return to IDLE.
REQ-030 Every select rise SHALL return the state machine to IDLE.
REQ-031 SCLK edges while select is inactive SHALL be ignored.
REQ-032 Changes on data_in after capture SHALL NOT affect the bits shifted out.
REQ-033 Latency: wr_stb and data_out update within 4 clk cycles of ucSEL_ rising at the pin.
REQ-034 Minimum clk frequency is 4x the SCLK frequency; no detection requirement below that.

Reset
REQ-035 While reset is high: state IDLE, counters zero, shift registers zero, synchroniser stages at idle levels (SCLK=CPOL, SEL=1, MOSI=0).
REQ-036 While reset is high: data_out all zero, wr_stb/rd_stb/frame_err/busy low, ucMISO 0.
REQ-037 Reset asserted mid-frame SHALL abort the frame with no wr_stb and no frame_err; the next frame starts from a fresh select fall.

Verification
REQ-038 Defaults (mode 0): write frame cmd 0x82, payload 0xDEADBEEF -> data_out ch2 = 0xDEADBEEF, wr_stb = 0b0100 one cycle, other channels 0, rd_stb[2] pulses.
REQ-039 Read ch1 with data_in ch1 = 0x12345678, cmd 0x01 -> MISO returns 8 zero bits then 0x12345678; rd_stb = 0b0010; no wr_stb.
REQ-040 Deselect after 20 of 40 bits on a write to ch0 -> frame_err one pulse, data_out unchanged, busy low, next full frame succeeds.
REQ-041 cmd 0x85 (CH=5 >= 4) write 0xFFFFFFFF -> no wr_stb, no rd_stb, MISO payload all zero, data_out unchanged.
REQ-042 Repeat REQ-038/039 for CPOL/CPHA = 0/1, 1/0 and 1/1 -> identical data_out and MISO bit streams.
REQ-043 Assert reset during payload bit 10 of a write to ch3 -> data_out all zero, no strobes, ucMISO 0; a subsequent complete frame works.
